dot_acc: RTL and testbench

DOT_ACC -- requirements
Module: dot_acc

---
 rtl/dot_acc_pkg.sv | 14 +
 rtl/dot_acc_adder.sv | 12 +
 rtl/dot_acc.sv | 79 +++++++
 tb/tb_dot_acc.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/dot_acc_pkg.sv
// Shared widths and FSM state encoding for the dot-product accumulator.
package dot_acc_pkg;

    localparam int ACC_W_DEF = 40;
    localparam int LEN_W_DEF = 8;
    localparam int TERM_W    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dot_acc_adder.sv
// Combinational accumulate adder; the caller zero-extends the incoming term.
module dot_acc_adder #(
    parameter int ACC_W = dot_acc_pkg::ACC_W_DEF
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] term,
    output logic [ACC_W-1:0] sum
);

    assign sum = acc + term;

endmodule

// File: rtl/dot_acc.sv
// Accumulates len unsigned 32-bit MAC terms and presents the sum with a valid/ready handshake.
module dot_acc
    import dot_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    input  logic [TERM_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_data,
    input  logic              out_ready,
    output logic              busy
);

    state_t            state, state_nxt;
    logic [ACC_W-1:0]  acc, acc_nxt, sum;
    logic [LEN_W-1:0]  cnt, cnt_nxt;
    logic              take;

    dot_acc_adder #(.ACC_W(ACC_W)) u_add (
        .acc  (acc),
        .term ({{(ACC_W-TERM_W){1'b0}}, in_data}),
        .sum  (sum)
    );

    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = acc;
    assign take      = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_nxt   = '0;
                    cnt_nxt   = len;
                    state_nxt = (len == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (take) begin
                    acc_nxt = sum;
                    cnt_nxt = cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1))
                        state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset wins over every other input, dropping any partial or pending sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_dot_acc.sv
// Directed self-checking bench for dot_acc; inputs driven and outputs sampled on the falling edge.
module tb_dot_acc;

    localparam int ACC_W = 40;
    localparam int LEN_W = 8;

    logic              clk = 1'b0;
    logic              rst, start, in_valid, out_ready;
    logic [LEN_W-1:0]  len;
    logic [31:0]       in_data;
    logic              in_ready, out_valid, busy;
    logic [ACC_W-1:0]  out_data;

    int n_cmp = 0;
    int n_err = 0;

    dot_acc #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);
        step();
        chk_idle("rst");
        chk("rst_out_data", 64'(out_data), 64'd0);
        rst = 1'b0;

        // len=3, terms 10,20,30 back-to-back
        out_ready = 1'b1;
        start = 1'b1; len = 8'd3;
        step();
        start = 1'b0; len = 8'd0;
        chk("t1_busy", 64'(busy), 64'd1);
        in_valid = 1'b1; in_data = 32'd10;
        chk("t1_in_ready", 64'(in_ready), 64'd1);
        step();
        in_data = 32'd20;
        step();
        in_data = 32'd30;
        chk("t1_no_early_valid", 64'(out_valid), 64'd0);
        step();
        in_valid = 1'b0;
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_data", 64'(out_data), 64'd60);
        chk("t1_in_ready_done", 64'(in_ready), 64'd0);
        step();
        chk_idle("t1_back");
        out_ready = 1'b0;

        // len=0: straight to DONE with sum 0
        start = 1'b1; len = 8'd0;
        chk("t2_in_ready_idle", 64'(in_ready), 64'd0);
        step();
        start = 1'b0;
        chk("t2_in_ready", 64'(in_ready), 64'd0);
        chk("t2_out_valid", 64'(out_valid), 64'd1);
        chk("t2_out_data", 64'(out_data), 64'd0);
        out_ready = 1'b1;
        step();
        chk_idle("t2_back");
        out_ready = 1'b0;

        // len=255 of all-ones terms: largest sum, must not wrap
        start = 1'b1; len = 8'd255;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
        for (int i = 0; i < 255; i++) begin
            if (i == 0 || i == 254) begin
                chk("t3_in_ready", 64'(in_ready), 64'd1);
                chk("t3_not_done", 64'(out_valid), 64'd0);
            end
            step();
        end
        in_valid = 1'b0;
        chk("t3_out_valid", 64'(out_valid), 64'd1);
        chk("t3_out_data", 64'(out_data), 64'hFE_FFFF_FF01);
        out_ready = 1'b1;
        step();
        chk_idle("t3_back");
        out_ready = 1'b0;

        // len=2 with 3-cycle gaps, held result, start ignored in DONE
        start = 1'b1; len = 8'd2;
        step();
        start = 1'b0; len = 8'd0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_gap_ready", 64'(in_ready), 64'd1);
            step();
        end
        chk("t4_gap_acc", 64'(out_data), 64'd0);
        in_valid = 1'b1; in_data = 32'd5;
        step();
        in_valid = 1'b0; in_data = 32'd99;
        for (int i = 0; i < 3; i++) step();
        chk("t4_gap_acc5", 64'(out_data), 64'd5);
        chk("t4_still_acc", 64'(busy), 64'd1);
        in_valid = 1'b1; in_data = 32'd6;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len   = (i == 2) ? 8'd9 : 8'd0;
            chk("t4_hold_valid", 64'(out_valid), 64'd1);
            chk("t4_hold_data", 64'(out_data), 64'd11);
            step();
        end
        start = 1'b0; len = 8'd0;
        out_ready = 1'b1;
        chk("t4_release_data", 64'(out_data), 64'd11);
        step();
        out_ready = 1'b0;
        chk_idle("t4_back");
        step();
        chk_idle("t4_start_ignored");

        // len=4, reset after two terms, then a clean len=1 run
        start = 1'b1; len = 8'd4;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'd1;
        step();
        in_data = 32'd2;
        step();
        chk("t5_partial", 64'(out_data), 64'd3);
        rst = 1'b1; start = 1'b1; len = 8'd1; out_ready = 1'b1; in_data = 32'd3;
        step();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk_idle("t5_rst");
        chk("t5_rst_data", 64'(out_data), 64'd0);
        step();
        chk_idle("t5_no_pulse");
        start = 1'b1; len = 8'd1;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'd7;
        step();
        in_valid = 1'b0;
        chk("t5_out_valid", 64'(out_valid), 64'd1);
        chk("t5_out_data", 64'(out_data), 64'd7);
        out_ready = 1'b1;
        step();
        chk_idle("t5_back");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
